// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its response buffer.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between memory and decode.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 2 * XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the storage array is left unreset; count qualifies every read, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches under a 2-credit limit and squashes stale responses on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [1:0]      outstanding;
  logic [1:0]      outstanding_next;
  logic [1:0]      drop_cnt;
  logic [1:0]      buf_count;
  logic            credit_ok;
  logic            req_fire;
  logic            buf_push;
  logic            buf_pop;
  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign credit_ok       = (3'(outstanding) + 3'(buf_count)) < 3'd2;

  // Gating with rst_n keeps the request low while reset is held, yet lets it rise in the very first cycle after release.
  assign imem_req_valid = rst_n && (state == FETCH) && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // NOTE: default assignment first so every path drives outstanding_next and no latch is inferred.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !imem_rsp_valid)
      outstanding_next = outstanding + 2'd1;
    else if (!req_fire && imem_rsp_valid)
      outstanding_next = outstanding - 2'd1;
  end

  // Responses in FETCH always belong to the current stream; rsp_pc tracks the address of the next one.
  assign buf_push = (state == FETCH) && imem_rsp_valid && !redirect_valid;
  assign buf_pop  = id_valid && id_ready;
  assign buf_in   = '{pc: rsp_pc, instr: imem_rsp_data};

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc       <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= outstanding_next;
        state    <= (outstanding_next != 2'd0) ? DRAIN : FETCH;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (buf_push) rsp_pc <= rsp_pc + XLEN'(4);
        if (state == DRAIN && imem_rsp_valid) begin
          drop_cnt <= drop_cnt - 2'd1;
          if (drop_cnt == 2'd1) state <= FETCH;
        end
      end
    end
  end

  fetch_buffer #(
    .WIDTH(2 * XLEN)
  ) u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (buf_push),
    .push_data(buf_in),
    .pop      (buf_pop),
    .flush    (redirect_valid),
    .head     (buf_head),
    .count    (buf_count)
  );

  assign id_valid = (buf_count != 2'd0);
  assign id_instr = id_valid ? buf_head.instr : NOP_INSTR;
  assign id_pc    = id_valid ? buf_head.pc    : RESET_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written redirect corners, randomized run against a stream model.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        rsp_ok;
    logic        idr;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_id_valid;
    logic [31:0] exp_id_pc;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          mem_lat = 1;
  mreq_t       mem_q[$];
  logic [31:0] exp_req_addr;
  logic [31:0] exp_id_pc;
  logic        redir_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, play the memory, check against the stream model, advance.
  task automatic step(input logic rdy, input logic rsp_ok, input logic redir,
                      input logic [31:0] tgt, input logic idr);
    int lat;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    id_ready       = idr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rsp_ok && mem_q.size() != 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q[0].addr);
      end
    end
    #1;
    if (redir_prev) check("id_valid_after_redirect", id_valid, 0);
    if (stall_prev && !redir_prev) begin
      check("hold_valid", imem_req_valid, 1);
      check("hold_addr", imem_req_addr, held_addr);
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      check("in_flight_le2", mem_q.size() <= 2, 1);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (id_valid && id_ready) begin
      check("id_pc", id_pc, exp_id_pc);
      check("id_instr", id_instr, mem_word(exp_id_pc));
      exp_id_pc = exp_id_pc + 32'd4;
      n_pop++;
    end
    if (redir) begin
      exp_req_addr = tgt & ~32'h3;
      exp_id_pc    = tgt & ~32'h3;
    end
    redir_prev = redir;
    stall_prev = imem_req_valid && !imem_req_ready;
    held_addr  = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_valid", imem_req_valid, 0);
    check("reset_req_addr", imem_req_addr, TB_RESET_PC);
    check("reset_id_valid", id_valid, 0);
    check("reset_id_instr", id_instr, NOP);
    check("reset_id_pc", id_pc, TB_RESET_PC);
    mem_q.delete();
    exp_req_addr = TB_RESET_PC;
    exp_id_pc    = TB_RESET_PC;
    redir_prev   = 1'b0;
    stall_prev   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Retire everything in flight with no new requests.
  task automatic quiesce();
    int n;
    for (n = 0; n < 50; n++) begin
      if (mem_q.size() == 0 && !id_valid) break;
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    end
    check("quiesce_timeout", n < 50, 1);
  endtask

  // Drain stale responses, checking that no request issues meanwhile, then expect resumption at target.
  task automatic drain_and_resume(input string tag, input logic [31:0] target);
    int n;
    for (n = 0; n < 20; n++) begin
      if (mem_q.size() == 0) break;
      check({tag, "_no_req_in_drain"}, imem_req_valid, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    end
    check({tag, "_drain_timeout"}, n < 20, 1);
    check({tag, "_resume_valid"}, imem_req_valid, 1);
    check({tag, "_resume_addr"}, imem_req_addr, target);
    for (n = 0; n < 20; n++) begin
      if (id_valid) break;
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    end
    check({tag, "_id_timeout"}, n < 20, 1);
    check({tag, "_first_id_pc"}, id_pc, target);
    check({tag, "_first_id_instr"}, id_instr, mem_word(target));
  endtask

  vec_t vecs[9];

  initial begin
    int pops_before;

    // Startup from reset with 1-cycle memory, decode stalled then released.
    vecs = '{
      '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100},
      '{1'b1, 1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100},
      '{1'b1, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104},
      '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h108},
      '{1'b0, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C}
    };

    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].exp_req_valid);
      check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_req_addr);
      check($sformatf("vec%0d_id_valid", i), id_valid, vecs[i].exp_id_valid);
      if (vecs[i].exp_id_valid) check($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_id_pc);
      step(vecs[i].rdy, vecs[i].rsp_ok, 1'b0, '0, vecs[i].idr);
    end

    // Memory back-pressure for three cycles: request held, PC frozen.
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", imem_req_valid, 1);
      check("stall_addr", imem_req_addr, 32'h110);
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    end
    check("stall_release_addr", imem_req_addr, 32'h110);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("advance_after_stall", imem_req_addr, 32'h114);

    // Redirect to an unaligned target with two requests outstanding.
    quiesce();
    mem_lat = 3;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("two_outstanding", mem_q.size(), 2);
    check("credit_stop", imem_req_valid, 0);
    step(1'b1, 1'b0, 1'b1, 32'h203, 1'b1);
    drain_and_resume("redir2", 32'h200);

    // Second redirect while draining overrides the first target.
    quiesce();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h506, 1'b1);
    drain_and_resume("redir_twice", 32'h504);

    // Redirect in the same cycle as a request accept and a response.
    quiesce();
    mem_lat = 1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("coincide_setup_valid", imem_req_valid, 1);
    step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    check("coincide_one_stale", mem_q.size(), 1);
    check("coincide_draining", imem_req_valid, 0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("coincide_still_draining", imem_req_valid, 0);
    drain_and_resume("coincide", 32'h300);

    // Address wrap at the top of the address space.
    quiesce();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    check("wrap_valid", imem_req_valid, 1);
    check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("wrap_addr_zero", imem_req_addr, 32'h0000_0000);

    // Randomized traffic against the stream model.
    mem_lat = 0;
    pops_before = n_pop;
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0,
           $urandom, ($urandom % 3) != 0);
    end
    check("random_progress", (n_pop - pops_before) > 200, 1);

    // Reset asserted mid-cycle during traffic must act at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_req_valid", imem_req_valid, 0);
    check("midreset_id_valid", id_valid, 0);
    check("midreset_id_instr", id_instr, NOP);
    do_reset();
    check("post_reset_first_req", imem_req_valid, 1);
    check("post_reset_first_addr", imem_req_addr, TB_RESET_PC);
    pops_before = n_pop;
    for (int c = 0; c < 1000; c++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0,
           $urandom, ($urandom % 3) != 0);
    end
    check("post_reset_progress", (n_pop - pops_before) > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid, in order, one per accepted request.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts.
- id_instr  out  32  instruction; bits [6:0] are the opcode consumed by main_control.
- id_pc  out  32  address of id_instr.

Function
REQ-003 SHALL keep a fetch PC; each accepted request (imem_req_valid & imem_req_ready) advances PC by 4, wrapping modulo 2^32.
REQ-004 SHALL hold imem_req_addr and imem_req_valid stable while imem_req_valid=1 and imem_req_ready=0.
REQ-005 SHALL buffer responses in a 2-entry FIFO of {pc, instr}; id_* present the FIFO head; a handshake is id_valid & id_ready; id_valid = FIFO non-empty.
REQ-006 SHALL assert imem_req_valid only when outstanding + FIFO occupancy < 2 (credit rule), so a response never finds the FIFO full.
REQ-007 SHALL track outstanding requests in a 2-bit counter: +1 on request accept, -1 on response, unchanged when both occur.
REQ-008 SHALL allow FIFO push and pop in the same cycle, including when full (pop frees the slot) and when empty with a response arriving (push only; no bypass, 1-cycle response-to-id_valid latency).
REQ-009 SHALL implement FSM {FETCH, DRAIN}; reset state FETCH.
REQ-010 On redirect_valid in any state: PC <= {redirect_pc[31:2],2'b00}, FIFO cleared, drop_cnt <= outstanding after this cycle's accept/response updates; next state DRAIN if that count > 0, else FETCH.
REQ-011 A request accepted in the redirect cycle SHALL be counted as stale; a response arriving in the redirect cycle SHALL be discarded.
REQ-012 In DRAIN SHALL issue no requests and discard responses, decrementing drop_cnt; on drop_cnt reaching 0 go to FETCH and resume at the redirected PC.
REQ-013 A second redirect during DRAIN SHALL overwrite PC and keep discarding until all stale responses are dropped.
REQ-014 id_valid SHALL be 0 in the cycle after a redirect.

Reset
REQ-015 While rst_n=0: PC=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state FETCH, imem_req_valid=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC.
REQ-016 Reset asserted mid-operation SHALL abandon all in-flight state immediately; responses after reset release for pre-reset requests are unsupported.
REQ-017 First request SHALL issue in the first cycle after rst_n deasserts.

Structure
REQ-018 Shared package SHALL hold fetch_state_t, NOP_INSTR and XLEN=32.
REQ-019 The FIFO SHALL be a sub-module fetch_buffer (depth 2, width 64, push/pop/flush/count).

Verification
REQ-020 Reset with RESET_PC=32'h100 -> first imem_req_addr=32'h100, then 32'h104; id_pc sequence 100,104,108.
REQ-021 id_ready=0 with 1-cycle memory -> exactly 2 requests issued, then imem_req_valid=0 until a pop.
REQ-022 imem_req_ready=0 for 3 cycles -> addr/valid held constant; no PC advance.
REQ-023 Redirect to 32'h203 with 2 outstanding -> both stale responses dropped, next request addr 32'h200, first id_pc 32'h200.
REQ-024 Redirect coinciding with request accept and response -> both stale; drop_cnt correct; no stale instruction reaches id_*.
REQ-025 Fetch at PC 32'hFFFF_FFFC -> next request addr 32'h0000_0000.
